// File: rtl/echo_pkg.sv
// Shared definitions for the axis_echo feed-forward echo stage.
//   state_e    : sequencing states of the one-sample-at-a-time datapath
//   SAT_W      : working width of the saturate helper
//   q_shift()  : fractional-bit count of a signed Q1.(W-1) gain
//   saturate() : clamp a signed value into a signed range of out_w bits
package echo_pkg;

   typedef enum logic [2:0] {
      S_CLR,
      S_IN,
      S_RD,
      S_MAC,
      S_OUT
   } state_e;

   localparam int unsigned SAT_W = 64;

   // Q1.(W-1) gains carry W-1 fractional bits; 15 for the default 16-bit gain.
   function automatic int unsigned q_shift(input int unsigned gain_width);
      return gain_width - 1;
   endfunction

   // Callers sign-extend into SAT_W bits and truncate the result to out_w bits.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] v,
      input int unsigned             out_w
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
      lo = -(SAT_W'(1) <<< (out_w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple-dual-port delay-line memory: one write port, one synchronous read port.
//   clk_i   : clock
//   we_i    : write enable, waddr_i/wdata_i written on the rising edge
//   re_i    : read enable, rdata_o updates one edge after raddr_i is sampled
// The array has no reset so it maps onto block RAM.
module delay_ram #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_W     = 12
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_W)-1];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rd_data_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rd_data_q;

endmodule

// File: rtl/axis_echo.sv
// Single-tap feed-forward echo: y[n] = sat(x[n] + g * x[n-D]).
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   s_axis_*             : input sample stream (tdata, tvalid, tready, tlast)
//   m_axis_*             : output sample stream (tdata, tvalid, tready, tlast)
//   cfg_delay            : echo delay D in samples, 0 disables the echo
//   cfg_gain             : echo gain g, signed Q1.(GAIN_WIDTH-1)
//   cfg_bypass           : pass input straight through; delay line still fed
// After reset the whole delay line is zeroed before the first sample is
// accepted. Each sample then walks S_IN -> S_RD -> S_MAC -> S_OUT.
module axis_echo
   import echo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned GAIN_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   input  logic [ADDR_W-1:0]     cfg_delay,
   input  logic [GAIN_WIDTH-1:0] cfg_gain,
   input  logic                  cfg_bypass
);

   localparam int unsigned QSHIFT = q_shift(GAIN_WIDTH);
   localparam int unsigned PROD_W = DATA_WIDTH + GAIN_WIDTH;
   localparam int unsigned SUM_W  = PROD_W + 1;

   state_e                       state_q, state_d;
   logic [ADDR_W-1:0]            clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]            rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0]            delay_q, delay_d;
   logic signed [DATA_WIDTH-1:0] x_q, x_d;
   logic signed [GAIN_WIDTH-1:0] gain_q, gain_d;
   logic                         last_q, last_d;
   logic                         bypass_q, bypass_d;
   logic                         s_tready_q, s_tready_d;
   logic                         m_tvalid_q, m_tvalid_d;
   logic                         m_tlast_q, m_tlast_d;
   logic [DATA_WIDTH-1:0]        m_tdata_q, m_tdata_d;

   logic                         ram_we;
   logic [ADDR_W-1:0]            ram_waddr;
   logic [DATA_WIDTH-1:0]        ram_wdata;
   logic                         ram_re;
   logic [DATA_WIDTH-1:0]        ram_rdata;

   logic signed [DATA_WIDTH-1:0] x_del;
   logic signed [PROD_W-1:0]     prod;
   logic signed [SUM_W-1:0]      scaled;
   logic signed [SUM_W-1:0]      sum;
   logic [DATA_WIDTH-1:0]        mac_result;

   delay_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (ADDR_W)
   ) u_delay_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (rd_addr_q),
      .rdata_o (ram_rdata)
   );

   // Echo arithmetic; ram_rdata is valid while in S_MAC.
   always_comb begin
      x_del      = (delay_q == '0) ? '0 : $signed(ram_rdata);
      prod       = PROD_W'(x_del) * PROD_W'(gain_q);
      scaled     = SUM_W'(prod >>> QSHIFT);
      sum        = SUM_W'(x_q) + scaled;
      mac_result = bypass_q ? x_q : DATA_WIDTH'(saturate(SAT_W'(sum), DATA_WIDTH));
   end

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_addr_d  = rd_addr_q;
      delay_d    = delay_q;
      x_d        = x_q;
      gain_d     = gain_q;
      last_d     = last_q;
      bypass_d   = bypass_q;
      s_tready_d = s_tready_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      m_tdata_d  = m_tdata_q;
      ram_we     = 1'b0;
      ram_waddr  = wr_ptr_q;
      ram_wdata  = x_q;
      ram_re     = 1'b0;

      case (state_q)
         S_CLR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d    = S_IN;
               s_tready_d = 1'b1;
            end
         end
         S_IN: begin
            if (s_axis_tvalid) begin
               x_d        = $signed(s_axis_tdata);
               last_d     = s_axis_tlast;
               delay_d    = cfg_delay;
               gain_d     = $signed(cfg_gain);
               bypass_d   = cfg_bypass;
               // Natural wrap of the ADDR_W-bit subtraction gives modulo DEPTH.
               rd_addr_d  = wr_ptr_q - cfg_delay;
               s_tready_d = 1'b0;
               state_d    = S_RD;
            end
         end
         S_RD: begin
            ram_re  = 1'b1;
            state_d = S_MAC;
         end
         S_MAC: begin
            m_tdata_d  = mac_result;
            m_tlast_d  = last_q;
            m_tvalid_d = 1'b1;
            // Read already happened in S_RD, so a sample never echoes itself.
            ram_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (m_axis_tready) begin
               m_tvalid_d = 1'b0;
               s_tready_d = 1'b1;
               state_d    = S_IN;
            end
         end
         default: begin
            state_d = S_CLR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_CLR;
         clr_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_addr_q  <= '0;
         delay_q    <= '0;
         x_q        <= '0;
         gain_q     <= '0;
         last_q     <= 1'b0;
         bypass_q   <= 1'b0;
         s_tready_q <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_addr_q  <= rd_addr_d;
         delay_q    <= delay_d;
         x_q        <= x_d;
         gain_q     <= gain_d;
         last_q     <= last_d;
         bypass_q   <= bypass_d;
         s_tready_q <= s_tready_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_tdata_q  <= m_tdata_d;
      end
   end

   assign s_axis_tready = s_tready_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tlast  = m_tlast_q;

endmodule

// File: tb/tb_axis_echo.sv
// Self-checking bench for axis_echo: directed vectors with literal expectations
// plus a history-array model checked on every output transfer.
module tb_axis_echo;

   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic [11:0] cfg_delay = '0;
   logic [15:0] cfg_gain = '0;
   logic        cfg_bypass = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_echo #(
      .DATA_WIDTH (16),
      .ADDR_W     (12),
      .GAIN_WIDTH (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .cfg_delay     (cfg_delay),
      .cfg_gain      (cfg_gain),
      .cfg_bypass    (cfg_bypass)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // y = sat16(x + floor(xd * g / 2^15)), xd = 0 when d == 0, y = x in bypass.
   function automatic logic [15:0] echo_ref(input int x, input int xd, input int g,
                                            input int d, input bit byp);
      longint s;
      logic [15:0] r;
      if (byp) begin
         s = x;
      end else begin
         if (d == 0) xd = 0;
         s = longint'(x) + ((longint'(xd) * longint'(g)) >>> 15);
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
      end
      r = s[15:0];
      return r;
   endfunction

   // Model and compare process.
   int          hist [DEPTH];
   int          wp = 0;
   logic [15:0] exp_q [$];
   logic        exp_last_q [$];
   int          acc_cyc = 0;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [15:0] prev_data = '0;
   logic        prev_last = 1'b0;

   always @(negedge clk) begin : monitor
      int xd;
      logic [15:0] e;
      logic el;
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) hist[i] = 0;
         wp = 0;
         exp_q.delete();
         exp_last_q.delete();
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (s_axis_tvalid && s_axis_tready) begin
            xd = hist[(wp - int'(cfg_delay) + DEPTH) % DEPTH];
            exp_q.push_back(echo_ref(int'($signed(s_axis_tdata)), xd,
                                     int'($signed(cfg_gain)), int'(cfg_delay), cfg_bypass));
            exp_last_q.push_back(s_axis_tlast);
            hist[wp] = int'($signed(s_axis_tdata));
            wp = (wp + 1) % DEPTH;
            acc_cyc = cyc;
         end
         if (m_axis_tvalid && !prev_valid) chk("latency", cyc - acc_cyc, 3);
         if (m_axis_tvalid) chk("s_tready_low_in_out", {31'b0, s_axis_tready}, 0);
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", {31'b0, m_axis_tvalid}, 1);
            chk("hold_data", {16'b0, m_axis_tdata}, {16'b0, prev_data});
            chk("hold_last", {31'b0, m_axis_tlast}, {31'b0, prev_last});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               el = exp_last_q.pop_front();
               chk("model_data", {16'b0, m_axis_tdata}, {16'b0, e});
               chk("model_last", {31'b0, m_axis_tlast}, {31'b0, el});
            end
         end
         prev_valid = m_axis_tvalid;
         prev_ready = m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
      end
   end

   // Release reset and count cycles until the delay line is cleared.
   task automatic release_and_measure();
      int n;
      bit seen_valid;
      bit ok;
      @(posedge clk);
      #1 reset = 1'b0;
      n = 0;
      seen_valid = 0;
      ok = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (m_axis_tvalid) seen_valid = 1;
         if (s_axis_tready) begin
            ok = 1;
            break;
         end
         n++;
      end
      chk("clear_done", {31'b0, ok}, 1);
      chk("clear_cycles", n, 4096);
      chk("tvalid_during_clear", {31'b0, seen_valid}, 0);
   endtask

   // Offer one sample; wait for its output and compare against literals.
   // Returns at the negedge where the output is valid (handshake consumed when ready).
   task automatic send(input string name, input logic [15:0] d, input logic l,
                       input logic [15:0] exp, input logic exp_last);
      bit ok;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_axis_tready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk({name, "_accept_timeout"}, 0, 1);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_axis_tvalid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk({name, "_output_timeout"}, 0, 1);
      end else begin
         chk(name, {16'b0, m_axis_tdata}, {16'b0, exp});
         chk({name, "_last"}, {31'b0, m_axis_tlast}, {31'b0, exp_last});
      end
      if (m_axis_tready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_cfg(input logic [11:0] d, input logic [15:0] g, input logic byp);
      cfg_delay  = d;
      cfg_gain   = g;
      cfg_bypass = byp;
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      bit ok;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_s_tready", {31'b0, s_axis_tready}, 0);
      chk("rst_m_tvalid", {31'b0, m_axis_tvalid}, 0);
      chk("rst_m_tdata", {16'b0, m_axis_tdata}, 0);
      chk("rst_m_tlast", {31'b0, m_axis_tlast}, 0);
      release_and_measure();
      @(posedge clk);
      #1;

      // Impulse, D=3, g=0.5
      set_cfg(12'd3, 16'h4000, 1'b0);
      send("imp0", 16'h4000, 1'b0, 16'h4000, 1'b0);
      send("imp1", 16'h0000, 1'b0, 16'h0000, 1'b0);
      send("imp2", 16'h0000, 1'b0, 16'h0000, 1'b0);
      send("imp3", 16'h0000, 1'b0, 16'h2000, 1'b0);
      send("imp4", 16'h0000, 1'b0, 16'h0000, 1'b0);

      // Saturation, D=1, g~1
      set_cfg(12'd1, 16'h7FFF, 1'b0);
      send("satp0", 16'h7000, 1'b0, 16'h7000, 1'b0);
      send("satp1", 16'h7000, 1'b0, 16'h7FFF, 1'b0);
      send("satz", 16'h0000, 1'b0, 16'h6FFF, 1'b0);
      send("satn0", 16'h9000, 1'b0, 16'h9000, 1'b0);
      send("satn1", 16'h9000, 1'b0, 16'h8000, 1'b0);

      // Backpressure: 0x1000 + 0.5*0x9000 = 4096 - 14336 = 0xD800
      set_cfg(12'd1, 16'h4000, 1'b0);
      m_axis_tready = 1'b0;
      send("bp", 16'h1000, 1'b1, 16'hD800, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_data", {16'b0, m_axis_tdata}, 32'h0000D800);
         chk("bp_s_tready", {31'b0, s_axis_tready}, 0);
      end
      @(posedge clk);
      #1 m_axis_tready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", {31'b0, m_axis_tvalid}, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_after_valid", {31'b0, m_axis_tvalid}, 0);
      chk("bp_after_s_tready", {31'b0, s_axis_tready}, 1);
      @(posedge clk);
      #1;

      // Bypass frame, then echo of its first sample at D=4
      set_cfg(12'd4, 16'h4000, 1'b1);
      send("byp0", 16'h0100, 1'b0, 16'h0100, 1'b0);
      send("byp1", 16'h0200, 1'b0, 16'h0200, 1'b0);
      send("byp2", 16'h0300, 1'b0, 16'h0300, 1'b0);
      send("byp3", 16'h0400, 1'b1, 16'h0400, 1'b1);
      set_cfg(12'd4, 16'h4000, 1'b0);
      send("echo_after_byp", 16'h0010, 1'b0, 16'h0090, 1'b0);

      // Reset during S_MAC
      s_axis_tdata  = 16'h1234;
      s_axis_tvalid = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_axis_tready) begin
            ok = 1;
            break;
         end
      end
      chk("mac_rst_accept", {31'b0, ok}, 1);
      @(posedge clk);
      #1 s_axis_tvalid = 1'b0;
      @(posedge clk);
      #3;
      chk("pre_rst_tdata", {16'b0, m_axis_tdata}, 32'h00000090);
      reset = 1'b1;
      #1;
      chk("async_rst_tdata", {16'b0, m_axis_tdata}, 0);
      chk("async_rst_tvalid", {31'b0, m_axis_tvalid}, 0);
      chk("async_rst_s_tready", {31'b0, s_axis_tready}, 0);
      repeat (3) @(posedge clk);
      release_and_measure();
      @(posedge clk);
      #1;

      // Post-reset impulse, D=2: no stale echo
      set_cfg(12'd2, 16'h4000, 1'b0);
      send("pr0", 16'h2000, 1'b0, 16'h2000, 1'b0);
      send("pr1", 16'h0000, 1'b0, 16'h0000, 1'b0);
      send("pr2", 16'h0000, 1'b0, 16'h1000, 1'b0);
      send("pr3", 16'h0000, 1'b0, 16'h0000, 1'b0);

      repeat (4) @(negedge clk);
      chk("model_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
